univ_shift_reg: RTL and testbench

//  Parametrised universal shift register: DEPTH stages of WIDTH-bit lanes.

---
 rtl/usr_pkg.sv | 15 +
 rtl/usr_stage.sv | 47 ++++
 rtl/univ_shift_reg.sv | 115 +++++++++++
 tb/tb_univ_shift_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: op encoding and its width.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package usr_pkg;

  localparam int USR_OP_W = 2;

  typedef enum logic [USR_OP_W-1:0] {
    USR_HOLD = 2'b00,
    USR_SHF  = 2'b01,
    USR_SHB  = 2'b10,
    USR_LOAD = 2'b11
  } usr_op_e;

endpackage

// File: rtl/usr_stage.sv
// One WIDTH-bit lane of the shift register with hold/fwd/bwd/load next-value mux.
// Latency: 1 cycle from selected source to q.
// Backpressure: none; en=0 holds the lane, rst/clr clear it.
module usr_stage
  import usr_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [USR_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    fwd_in,
  input  logic [WIDTH-1:0]    bwd_in,
  input  logic [WIDTH-1:0]    load_in,
  output logic [WIDTH-1:0]    q
);

  logic [WIDTH-1:0] stage_d;
  logic [WIDTH-1:0] stage_q;

  // Select the next lane value; op is don't-care while en is low.
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      unique case (usr_op_e'(op))
        USR_SHF:  stage_d = fwd_in;
        USR_SHB:  stage_d = bwd_in;
        USR_LOAD: stage_d = load_in;
        default:  stage_d = stage_q;
      endcase
    end
  end

  // Lane register; reset and clear both discard the held value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold/shift fwd/shift bwd/load) with saturating fill count.
// Latency: DEPTH cycles ser_in_f -> ser_out_f on SHF; 1 cycle for LOAD to par_out.
// Backpressure: none; en=0 holds. Define USR_ROTATE_EN to add the rot port (wrap-around shifts).
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4  // must be >= 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic [USR_OP_W-1:0]        op,
`ifdef USR_ROTATE_EN
  input  logic                       rot,
`endif
  input  logic [WIDTH-1:0]           ser_in_f,
  input  logic [WIDTH-1:0]           ser_in_b,
  input  logic [DEPTH*WIDTH-1:0]     par_in,
  output logic [WIDTH-1:0]           ser_out_f,
  output logic [WIDTH-1:0]           ser_out_b,
  output logic [DEPTH*WIDTH-1:0]     par_out,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       out_valid
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [DEPTH*WIDTH-1:0] stages;
  logic [WIDTH-1:0]       head_f;   // value entering stage[0] on SHF
  logic [WIDTH-1:0]       tail_b;   // value entering stage[DEPTH-1] on SHB
  logic                   rot_on;
  logic [FILL_W-1:0]      fill_d;
  logic [FILL_W-1:0]      fill_q;

`ifdef USR_ROTATE_EN
  assign rot_on = rot;
`else
  assign rot_on = 1'b0;
`endif

  // End-of-line sources: serial inputs normally, opposite end when rotating.
  always_comb begin
    head_f = ser_in_f;
    tail_b = ser_in_b;
    if (rot_on) begin
      head_f = stages[(DEPTH-1)*WIDTH +: WIDTH];
      tail_b = stages[WIDTH-1:0];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] fwd_src;
    logic [WIDTH-1:0] bwd_src;

    if (i == 0) begin : g_fwd_head
      assign fwd_src = head_f;
    end else begin : g_fwd_chain
      assign fwd_src = stages[(i-1)*WIDTH +: WIDTH];
    end

    if (i == DEPTH - 1) begin : g_bwd_tail
      assign bwd_src = tail_b;
    end else begin : g_bwd_chain
      assign bwd_src = stages[(i+1)*WIDTH +: WIDTH];
    end

    usr_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .en      (en),
      .op      (op),
      .fwd_in  (fwd_src),
      .bwd_in  (bwd_src),
      .load_in (par_in[i*WIDTH +: WIDTH]),
      .q       (stages[i*WIDTH +: WIDTH])
    );
  end

  // Fill tracking: shifts count up and saturate, a load fills everything,
  // a rotation only moves existing data so the count stays put.
  always_comb begin
    fill_d = fill_q;
    if (en) begin
      unique case (usr_op_e'(op))
        USR_SHF, USR_SHB: begin
          if (!rot_on && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        USR_LOAD: fill_d = FILL_MAX;
        default:  fill_d = fill_q;
      endcase
    end
  end

  // Fill counter register; rst and clr restart the count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign ser_out_f = stages[(DEPTH-1)*WIDTH +: WIDTH];
  assign ser_out_b = stages[WIDTH-1:0];
  assign par_out   = stages;
  assign fill      = fill_q;
  assign out_valid = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int W = 1;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, clr, en;
  logic [1:0] op;
  logic       rot;
  logic       ser_in_f, ser_in_b;
  logic [3:0] par_in;
  logic       ser_out_f, ser_out_b;
  logic [3:0] par_out;
  logic [2:0] fill;
  logic       out_valid;

  typedef struct packed {
    logic [3:0] par;
    logic [2:0] fill;
    logic       ov;
    logic       sf;
    logic       sb;
  } exp_t;

  exp_t exp_q[$];
  logic [3:0] m_st;
  int         m_fill;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .en        (en),
    .op        (op),
`ifdef USR_ROTATE_EN
    .rot       (rot),
`endif
    .ser_in_f  (ser_in_f),
    .ser_in_b  (ser_in_b),
    .par_in    (par_in),
    .ser_out_f (ser_out_f),
    .ser_out_b (ser_out_b),
    .par_out   (par_out),
    .fill      (fill),
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour of one clock edge; pushes the expected outputs.
  task automatic model_edge(input logic r, input logic c, input logic e, input logic [1:0] o,
                            input logic ro, input logic sf, input logic sb, input logic [3:0] p);
    exp_t x;
    if (r || c) begin
      m_st = 4'b0; m_fill = 0;
    end else if (e) begin
      case (o)
        2'b01: begin
          if (ro) m_st = {m_st[2:0], m_st[3]};
          else begin
            m_st = {m_st[2:0], sf};
            if (m_fill < D) m_fill++;
          end
        end
        2'b10: begin
          if (ro) m_st = {m_st[0], m_st[3:1]};
          else begin
            m_st = {sb, m_st[3:1]};
            if (m_fill < D) m_fill++;
          end
        end
        2'b11: begin m_st = p; m_fill = D; end
        default: ;
      endcase
    end
    x.par = m_st; x.fill = 3'(m_fill); x.ov = (m_fill == D);
    x.sf = m_st[3]; x.sb = m_st[0];
    exp_q.push_back(x);
  endtask

  // Drive one cycle of stimulus, clock it, then compare against the scoreboard.
  task automatic step(input logic r, input logic c, input logic e, input logic [1:0] o,
                      input logic ro, input logic sf, input logic sb, input logic [3:0] p);
    exp_t x;
    rst = r; clr = c; en = e; op = o; rot = ro; ser_in_f = sf; ser_in_b = sb; par_in = p;
    model_edge(r, c, e, o, ro, sf, sb, p);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_assert++; n_fail++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      x = exp_q.pop_front();
      check("par_out",   8'(par_out),   8'(x.par));
      check("fill",      8'(fill),      8'(x.fill));
      check("out_valid", 8'(out_valid), 8'(x.ov));
      check("ser_out_f", 8'(ser_out_f), 8'(x.sf));
      check("ser_out_b", 8'(ser_out_b), 8'(x.sb));
    end
  endtask

  initial begin
    logic [3:0] bits;
    rst = 1'b1; clr = 1'b0; en = 1'b0; op = 2'b00; rot = 1'b0;
    ser_in_f = 1'b0; ser_in_b = 1'b0; par_in = 4'h0;
    m_st = 4'h0; m_fill = 0;
    #1;

    // 1. Reset held two cycles while shifting toggling data
    step(1, 0, 1, 2'b01, 0, 1, 1, 4'hF);
    step(1, 0, 1, 2'b01, 0, 0, 0, 4'h5);
    check("rst_par",  8'(par_out),   8'h00);
    check("rst_fill", 8'(fill),      8'h00);
    check("rst_ov",   8'(out_valid), 8'h00);

    // 2. SISO: shift in 1,0,1,1 then keep shifting zeros to drain
    bits = 4'b1101;  // applied LSB first: 1,0,1,1
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 2'b01, 0, bits[i], 0, 4'h0);
      check("siso_ov", 8'(out_valid), (i == 3) ? 8'h01 : 8'h00);
    end
    check("siso_out0", 8'(ser_out_f), 8'h01);
    step(0, 0, 1, 2'b01, 0, 0, 0, 4'h0);
    check("siso_out1", 8'(ser_out_f), 8'h00);
    step(0, 0, 1, 2'b01, 0, 0, 0, 4'h0);
    check("siso_out2", 8'(ser_out_f), 8'h01);
    step(0, 0, 1, 2'b01, 0, 0, 0, 4'h0);
    check("siso_out3", 8'(ser_out_f), 8'h01);

    // 3. PISO: load 1010 then shift backward with zeros
    step(1, 0, 0, 2'b00, 0, 0, 0, 4'h0);
    step(0, 0, 1, 2'b01, 0, 1, 0, 4'h0);  // partial fill before load
    step(0, 0, 1, 2'b11, 0, 0, 0, 4'b1010);
    check("piso_fill_load", 8'(fill),      8'h04);
    check("piso_b0",        8'(ser_out_b), 8'h00);
    step(0, 0, 1, 2'b10, 0, 0, 0, 4'h0);
    check("piso_b1", 8'(ser_out_b), 8'h01);
    step(0, 0, 1, 2'b10, 0, 0, 0, 4'h0);
    check("piso_b2", 8'(ser_out_b), 8'h00);
    step(0, 0, 1, 2'b10, 0, 0, 0, 4'h0);
    check("piso_b3", 8'(ser_out_b), 8'h01);
    step(0, 0, 1, 2'b10, 0, 0, 0, 4'h0);
    check("piso_par_end", 8'(par_out), 8'h00);
    check("piso_fill",    8'(fill),    8'h04);

    // 4. Hold with en=0 ignores op; clr beats en
    step(0, 0, 1, 2'b11, 0, 0, 0, 4'b0110);
    step(0, 0, 0, 2'b11, 0, 1, 1, 4'b1001);
    check("hold_par", 8'(par_out), 8'h06);
    step(0, 0, 1, 2'b00, 0, 1, 1, 4'b1111);
    check("hold_op", 8'(par_out), 8'h06);
    step(0, 1, 1, 2'b11, 0, 1, 1, 4'b1111);
    check("clr_par",  8'(par_out), 8'h00);
    check("clr_fill", 8'(fill),    8'h00);

    // 5. Saturation: six forward shifts from empty
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 2'b01, 0, 1'($urandom_range(0, 1)), 0, 4'h0);
      check("sat_fill", 8'(fill), 8'((i < 4) ? i + 1 : 4));
    end
    // mixed random traffic against the model
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

`ifdef USR_ROTATE_EN
    // 6. Rotation keeps data and fill
    step(0, 0, 1, 2'b11, 0, 0, 0, 4'b0001);
    bits = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 2'b01, 1, 1, 1, 4'h0);
      bits = {bits[2:0], bits[3]};
      check("rot_par",  8'(par_out), 8'(bits));
      check("rot_fill", 8'(fill),    8'h04);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
